// File: rtl/evm_pkg.sv
// Shared EVM definitions: candidate count/width, ballot FSM states and
// the candidate-code type used on the vote interface.
package evm_pkg;

  localparam int NUM_CAND = 4;
  localparam int CAND_W   = 2;

  typedef logic [CAND_W-1:0] cand_t;

  typedef enum logic [2:0] {
    LOCKED,
    ARMED,
    DEBOUNCE,
    SEND,
    RELEASE
  } state_t;

  // Encode a one-hot button vector as a candidate code; bit n -> code n.
  function automatic cand_t onehot_to_cand(input logic [NUM_CAND-1:0] oh);
    cand_t code;
    code = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (oh[i]) code = cand_t'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw candidate buttons.
module btn_sync
  import evm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CAND-1:0] btn,
  output logic [NUM_CAND-1:0] btn_s
);

  logic [NUM_CAND-1:0] sync1_reg;
  logic [NUM_CAND-1:0] sync2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAND; gi++) begin : g_bit
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= btn[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  assign btn_s = sync2_reg;

endmodule

// File: rtl/ballot_unit.sv
// Voter-side ballot front end: arms on ballot_en, debounces one candidate
// press, hands exactly one vote to the tally unit, then locks.
module ballot_unit
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ballot_en,
  input  logic [NUM_CAND-1:0] btn,
  input  logic                vote_ready,
  output logic                vote_valid,
  output logic [CAND_W-1:0]   vote_cand,
  output logic                ready_led,
  output logic                multi_press,
  output logic [CNT_W-1:0]    ballots_cast
);

  logic [NUM_CAND-1:0] btn_s;

  state_t              state_reg, state_next;
  cand_t               cand_reg, cand_next;
  logic [NUM_CAND-1:0] onehot_reg, onehot_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [CNT_W-1:0]    ballots_reg, ballots_next;
  logic                multi_press_reg, multi_hold_reg;
  logic                multi_cond;
  logic                btn_multi, btn_onehot;

  btn_sync u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .btn_s (btn_s)
  );

  assign btn_multi  = (btn_s & (btn_s - 1'b1)) != '0;
  assign btn_onehot = (btn_s != '0) && !btn_multi;

  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    onehot_next  = onehot_reg;
    cnt_next     = cnt_reg;
    ballots_next = ballots_reg;
    multi_cond   = 1'b0;
    case (state_reg)
      LOCKED: begin
        if (ballot_en) state_next = ARMED;
      end
      ARMED: begin
        if (btn_onehot) begin
          cand_next   = onehot_to_cand(btn_s);
          onehot_next = btn_s;
          cnt_next    = 8'd1;
          state_next  = DEBOUNCE;
        end else if (btn_multi) begin
          multi_cond = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (btn_s != onehot_reg) begin
          cnt_next   = 8'd0;
          state_next = ARMED;
        end else if (cnt_reg == 8'(DEBOUNCE_CYCLES)) begin
          state_next = SEND;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      SEND: begin
        if (vote_ready) begin
          if (ballots_reg != '1) ballots_next = ballots_reg + 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        // Hold off re-locking until the voter lets go of every button.
        if (btn_s == '0) state_next = LOCKED;
      end
      default: state_next = LOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= LOCKED;
      cand_reg        <= '0;
      onehot_reg      <= '0;
      cnt_reg         <= '0;
      ballots_reg     <= '0;
      multi_press_reg <= 1'b0;
      multi_hold_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cand_reg        <= cand_next;
      onehot_reg      <= onehot_next;
      cnt_reg         <= cnt_next;
      ballots_reg     <= ballots_next;
      // One pulse per multi-press episode, not one per cycle it is held.
      multi_press_reg <= multi_cond && !multi_hold_reg;
      multi_hold_reg  <= multi_cond;
    end
  end

  assign vote_valid   = (state_reg == SEND);
  assign ready_led    = (state_reg == ARMED);
  assign vote_cand    = cand_reg;
  assign multi_press  = multi_press_reg;
  assign ballots_cast = ballots_reg;

endmodule

// File: tb/tb_ballot_unit.sv
// Directed self-checking bench for ballot_unit; a second 2-bit-counter
// instance shares the stimulus to exercise ballots_cast saturation.
module tb_ballot_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ballot_en;
  logic [3:0]  btn;
  logic        vote_ready;
  logic        vote_valid, ready_led, multi_press;
  logic [1:0]  vote_cand;
  logic [15:0] ballots_cast;
  logic        vote_valid_s, ready_led_s, multi_press_s;
  logic [1:0]  vote_cand_s;
  logic [1:0]  ballots_cast_s;

  int total = 0;
  int bad   = 0;
  logic mp_seen;

  always #5 clk = ~clk;

  ballot_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ballot_en    (ballot_en),
    .btn          (btn),
    .vote_ready   (vote_ready),
    .vote_valid   (vote_valid),
    .vote_cand    (vote_cand),
    .ready_led    (ready_led),
    .multi_press  (multi_press),
    .ballots_cast (ballots_cast)
  );

  ballot_unit #(.CNT_W(2)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .ballot_en    (ballot_en),
    .btn          (btn),
    .vote_ready   (vote_ready),
    .vote_valid   (vote_valid_s),
    .vote_cand    (vote_cand_s),
    .ready_led    (ready_led_s),
    .multi_press  (multi_press_s),
    .ballots_cast (ballots_cast_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic arm();
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ballot_en = 1'b0; btn = 4'b0000; vote_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(vote_valid), 32'd0);
    chk("rst_cand",  32'(vote_cand), 32'd0);
    chk("rst_led",   32'(ready_led), 32'd0);
    chk("rst_multi", 32'(multi_press), 32'd0);
    chk("rst_count", 32'(ballots_cast), 32'd0);
    reset = 1'b0;
    tick();

    // Basic vote: candidate 2, ready already high
    arm();
    chk("basic_led", 32'(ready_led), 32'd1);
    btn = 4'b0100; vote_ready = 1'b1;
    repeat (6) tick();
    chk("basic_early", 32'(vote_valid), 32'd0);
    tick();
    chk("basic_valid", 32'(vote_valid), 32'd1);
    chk("basic_cand",  32'(vote_cand), 32'd2);
    tick();
    chk("basic_done",  32'(vote_valid), 32'd0);
    chk("basic_count", 32'(ballots_cast), 32'd1);
    repeat (3) tick();
    btn = 4'b0000;
    repeat (4) tick();
    chk("basic_lock", 32'(ready_led), 32'd0);

    // Bounce: 2-cycle toggles never complete debounce
    arm();
    for (int i = 0; i < 6; i++) begin
      btn = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      chk("bounce_quiet", 32'(vote_valid), 32'd0);
      tick();
      chk("bounce_quiet", 32'(vote_valid), 32'd0);
    end
    btn = 4'b0001;
    repeat (6) tick();
    chk("bounce_early", 32'(vote_valid), 32'd0);
    tick();
    chk("bounce_valid", 32'(vote_valid), 32'd1);
    chk("bounce_cand",  32'(vote_cand), 32'd0);
    tick();
    chk("bounce_count", 32'(ballots_cast), 32'd2);
    btn = 4'b0000;
    repeat (4) tick();

    // Multi-press then a clean single press
    arm();
    btn = 4'b0011;
    mp_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      mp_seen = mp_seen | multi_press;
      chk("multi_novote", 32'(vote_valid), 32'd0);
    end
    chk("multi_pulse", 32'(mp_seen), 32'd1);
    chk("multi_armed", 32'(ready_led), 32'd1);
    btn = 4'b1000;
    repeat (6) tick();
    chk("multi_early", 32'(vote_valid), 32'd0);
    tick();
    chk("multi_valid", 32'(vote_valid), 32'd1);
    chk("multi_cand",  32'(vote_cand), 32'd3);
    tick();
    chk("multi_count", 32'(ballots_cast), 32'd3);
    btn = 4'b0000;
    repeat (4) tick();

    // Backpressure: vote held while buttons wander
    vote_ready = 1'b0;
    arm();
    btn = 4'b0010;
    repeat (7) tick();
    chk("bp_valid", 32'(vote_valid), 32'd1);
    chk("bp_cand",  32'(vote_cand), 32'd1);
    for (int i = 0; i < 20; i++) begin
      btn = 4'(i);
      tick();
      chk("bp_hold_valid", 32'(vote_valid), 32'd1);
      chk("bp_hold_cand",  32'(vote_cand), 32'd1);
      chk("bp_hold_count", 32'(ballots_cast), 32'd3);
    end
    vote_ready = 1'b1;
    tick();
    chk("bp_done",  32'(vote_valid), 32'd0);
    chk("bp_count", 32'(ballots_cast), 32'd4);
    btn = 4'b0000;
    repeat (4) tick();

    // Lock and repeat, vote 5 also lands on the saturated instance
    arm();
    btn = 4'b0001;
    repeat (7) tick();
    chk("lock_valid",     32'(vote_valid), 32'd1);
    chk("sat_valid",      32'(vote_valid_s), 32'd1);
    tick();
    chk("lock_count",     32'(ballots_cast), 32'd5);
    chk("sat_count",      32'(ballots_cast_s), 32'd3);
    arm();
    chk("lock_ignored",   32'(ready_led), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lock_novote",  32'(vote_valid), 32'd0);
    end
    chk("lock_count2",    32'(ballots_cast), 32'd5);
    btn = 4'b0000;
    repeat (4) tick();
    chk("lock_idle",      32'(ready_led), 32'd0);
    arm();
    chk("lock_rearm",     32'(ready_led), 32'd1);

    // Reset while a vote is pending
    vote_ready = 1'b0;
    btn = 4'b0100;
    repeat (7) tick();
    chk("rs_valid_pre", 32'(vote_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_valid", 32'(vote_valid), 32'd0);
    chk("rs_count", 32'(ballots_cast), 32'd0);
    chk("rs_led",   32'(ready_led), 32'd0);
    chk("rs_cand",  32'(vote_cand), 32'd0);
    ballot_en = 1'b1;
    tick();
    chk("rs_en_wins", 32'(ready_led), 32'd0);
    ballot_en = 1'b0; btn = 4'b0000; reset = 1'b0;
    repeat (2) tick();
    chk("rs_locked", 32'(ready_led), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
